// File: rtl/sram_pad_ctrl.sv
// Request-level SRAM controller: turns a valid/ready request stream into registered
// pad strobes with wait states, bus turnaround and outstanding-read return matching.
module sram_pad_ctrl #(
  parameter int ADDR_BITS       = 20,
  parameter int DATA_BITS       = 16,
  parameter int WAIT_STATES     = 0,
  parameter int TURNAROUND      = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [ADDR_BITS-1:0] pad_addr,
  output logic [DATA_BITS-1:0] pad_write_data,
  output logic                 pad_write_data_enable,
  output logic                 pad_ce_n,
  output logic                 pad_we_n,
  output logic                 pad_oe_n,
  input  logic [DATA_BITS-1:0] pad_read_data,
  input  logic                 pad_read_data_valid
);

  typedef enum logic [1:0] {IDLE, TURN, ACCESS} state_e;

  localparam logic [2:0] WsVal  = 3'(WAIT_STATES);
  localparam logic [2:0] TaVal  = 3'(TURNAROUND);
  localparam logic [3:0] MaxVal = 4'(MAX_OUTSTANDING);

  state_e               state_q, state_d;
  logic [2:0]           waitCnt_q, waitCnt_d;
  logic [1:0]           turnCnt_q, turnCnt_d;
  logic [1:0]           idleCnt_q, idleCnt_d;
  logic                 lastValid_q, lastValid_d;
  logic                 lastWe_q, lastWe_d;
  logic                 reqWe_q, reqWe_d;
  logic [ADDR_BITS-1:0] reqAddr_q, reqAddr_d;
  logic [DATA_BITS-1:0] reqWdata_q, reqWdata_d;
  logic [3:0]           outstanding_q, outstanding_d;
  logic [2:0]           pulseCnt_q, pulseCnt_d;
  logic [ADDR_BITS-1:0] padAddr_q, padAddr_d;
  logic [DATA_BITS-1:0] padWdata_q, padWdata_d;
  logic                 padWde_q, padWde_d;
  logic                 ceN_q, ceN_d;
  logic                 weN_q, weN_d;
  logic                 oeN_q, oeN_d;
  logic                 rdValid_q, rdValid_d;
  logic [DATA_BITS-1:0] rdData_q, rdData_d;

  logic       lastCycle;
  logic       accept;
  logic [2:0] idleAvail;
  logic [2:0] turnNeed;
  logic       pulseSeen;
  logic       forward;
  logic       accessNext;

  assign lastCycle = (state_q == ACCESS) && (waitCnt_q == WsVal);
  assign req_ready = !reset && ((state_q == IDLE) || lastCycle) && (outstanding_q < MaxVal);
  assign accept    = req_valid && req_ready;

  // Idle cycles already spent count toward the turnaround; the current IDLE cycle counts too.
  assign idleAvail = (state_q == ACCESS) ? 3'd0 :
                     (idleCnt_q == 2'd3) ? 3'd3 : {1'b0, idleCnt_q} + 3'd1;
  assign turnNeed  = (lastValid_q && (req_we != lastWe_q) && (TaVal > idleAvail)) ?
                     (TaVal - idleAvail) : 3'd0;

  // Only the last pulse of each return group is forwarded; pulses with nothing outstanding are stale.
  assign pulseSeen = pad_read_data_valid && (outstanding_q != 4'd0);
  assign forward   = pulseSeen && (pulseCnt_q == WsVal);

  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    turnCnt_d   = turnCnt_q;
    idleCnt_d   = (state_q == ACCESS) ? 2'd0 :
                  (idleCnt_q == 2'd3) ? 2'd3 : idleCnt_q + 2'd1;
    lastValid_d = lastValid_q;
    lastWe_d    = lastWe_q;
    reqWe_d     = reqWe_q;
    reqAddr_d   = reqAddr_q;
    reqWdata_d  = reqWdata_q;

    case (state_q)
      TURN: begin
        if (turnCnt_q == 2'd0) begin
          state_d   = ACCESS;
          waitCnt_d = 3'd0;
        end else begin
          turnCnt_d = turnCnt_q - 2'd1;
        end
      end
      ACCESS: begin
        if (lastCycle) begin
          state_d = IDLE;
        end else begin
          waitCnt_d = waitCnt_q + 3'd1;
        end
      end
      default: ;
    endcase

    if (accept) begin
      reqWe_d     = req_we;
      reqAddr_d   = req_addr;
      reqWdata_d  = req_wdata;
      lastValid_d = 1'b1;
      lastWe_d    = req_we;
      waitCnt_d   = 3'd0;
      if (turnNeed != 3'd0) begin
        state_d   = TURN;
        turnCnt_d = 2'(turnNeed - 3'd1);
      end else begin
        state_d = ACCESS;
      end
    end

    outstanding_d = outstanding_q + {3'b000, accept && !req_we} - {3'b000, forward};
    pulseCnt_d    = pulseCnt_q;
    if (pulseSeen) begin
      pulseCnt_d = forward ? 3'd0 : pulseCnt_q + 3'd1;
    end

    // Pad outputs are registered, so they are derived from the state about to be entered.
    accessNext = (state_d == ACCESS);
    padAddr_d  = accessNext ? reqAddr_d : padAddr_q;
    padWdata_d = accessNext ? reqWdata_d : padWdata_q;
    ceN_d      = !accessNext;
    weN_d      = !(accessNext && reqWe_d);
    oeN_d      = !(accessNext && !reqWe_d);
    padWde_d   = accessNext && reqWe_d;
    rdValid_d  = forward;
    rdData_d   = forward ? pad_read_data : rdData_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      waitCnt_q     <= 3'd0;
      turnCnt_q     <= 2'd0;
      idleCnt_q     <= 2'd0;
      lastValid_q   <= 1'b0;
      lastWe_q      <= 1'b0;
      reqWe_q       <= 1'b0;
      reqAddr_q     <= '0;
      reqWdata_q    <= '0;
      outstanding_q <= 4'd0;
      pulseCnt_q    <= 3'd0;
      padAddr_q     <= '0;
      padWdata_q    <= '0;
      padWde_q      <= 1'b0;
      ceN_q         <= 1'b1;
      weN_q         <= 1'b1;
      oeN_q         <= 1'b1;
      rdValid_q     <= 1'b0;
      rdData_q      <= '0;
    end else begin
      state_q       <= state_d;
      waitCnt_q     <= waitCnt_d;
      turnCnt_q     <= turnCnt_d;
      idleCnt_q     <= idleCnt_d;
      lastValid_q   <= lastValid_d;
      lastWe_q      <= lastWe_d;
      reqWe_q       <= reqWe_d;
      reqAddr_q     <= reqAddr_d;
      reqWdata_q    <= reqWdata_d;
      outstanding_q <= outstanding_d;
      pulseCnt_q    <= pulseCnt_d;
      padAddr_q     <= padAddr_d;
      padWdata_q    <= padWdata_d;
      padWde_q      <= padWde_d;
      ceN_q         <= ceN_d;
      weN_q         <= weN_d;
      oeN_q         <= oeN_d;
      rdValid_q     <= rdValid_d;
      rdData_q      <= rdData_d;
    end
  end

  assign pad_addr              = padAddr_q;
  assign pad_write_data        = padWdata_q;
  assign pad_write_data_enable = padWde_q;
  assign pad_ce_n              = ceN_q;
  assign pad_we_n              = weN_q;
  assign pad_oe_n              = oeN_q;
  assign rd_valid              = rdValid_q;
  assign rd_data               = rdData_q;

endmodule

// File: tb/tb_sram_pad_ctrl.sv
// Randomized bench for sram_pad_ctrl: two differently parameterized instances are checked
// every cycle against a schedule-based reference model (access windows, return groups).
module tb_sram_pad_ctrl;

  localparam int AB   = 20;
  localparam int DB   = 16;
  localparam int LAT  = 3;
  localparam int NCYC = 3000;
  localparam int WSP [2] = '{0, 2};
  localparam int TAP [2] = '{2, 3};
  localparam int MXP [2] = '{2, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          reqValid  [2];
  logic          reqReady  [2];
  logic          reqWe     [2];
  logic [AB-1:0] reqAddr   [2];
  logic [DB-1:0] reqWdata  [2];
  logic          rdValid   [2];
  logic [DB-1:0] rdData    [2];
  logic [AB-1:0] padAddr   [2];
  logic [DB-1:0] padWdata  [2];
  logic          padWde    [2];
  logic          ceN       [2];
  logic          weN       [2];
  logic          oeN       [2];
  logic [DB-1:0] padRdata  [2];
  logic          padRvalid [2];

  sram_pad_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .WAIT_STATES(WSP[0]),
                  .TURNAROUND(TAP[0]), .MAX_OUTSTANDING(MXP[0])) u0 (
    .clk(clk), .reset(reset), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .req_we(reqWe[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
    .rd_valid(rdValid[0]), .rd_data(rdData[0]), .pad_addr(padAddr[0]),
    .pad_write_data(padWdata[0]), .pad_write_data_enable(padWde[0]),
    .pad_ce_n(ceN[0]), .pad_we_n(weN[0]), .pad_oe_n(oeN[0]),
    .pad_read_data(padRdata[0]), .pad_read_data_valid(padRvalid[0]));

  sram_pad_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .WAIT_STATES(WSP[1]),
                  .TURNAROUND(TAP[1]), .MAX_OUTSTANDING(MXP[1])) u1 (
    .clk(clk), .reset(reset), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .req_we(reqWe[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
    .rd_valid(rdValid[1]), .rd_data(rdData[1]), .pad_addr(padAddr[1]),
    .pad_write_data(padWdata[1]), .pad_write_data_enable(padWde[1]),
    .pad_ce_n(ceN[1]), .pad_we_n(weN[1]), .pad_oe_n(oeN[1]),
    .pad_read_data(padRdata[1]), .pad_read_data_valid(padRvalid[1]));

  int checks = 0;
  int passes = 0;

  // Reference model: future access windows per cycle slot, outstanding reads, return grouping.
  bit            expAcc   [2][64];
  bit            expWe    [2][64];
  logic [AB-1:0] expAddrS [2][64];
  logic [DB-1:0] expWdS   [2][64];
  logic [AB-1:0] holdAddr [2];
  int            accessEnd[2];
  bit            lastValid[2];
  bit            lastWe   [2];
  int            outCount [2];
  int            groupCnt [2];
  bit            expRdValid[2];
  logic [DB-1:0] expRdData [2];
  bit            burstWe  [2];

  // Pad block model: each read access cycle yields one return pulse LAT cycles later (or later if withheld).
  int padT    [2][256];
  int padHead [2];
  int padTail [2];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input int k);
    int  vPct;
    int  wPct;
    bit  rel;
    reset = (k < 4) || (k == 1150) || (k >= 1231 && $urandom_range(0, 199) == 0);
    for (int i = 0; i < 2; i++) begin
      wPct = 50;
      if (k < 800) begin
        vPct = 60; rel = ($urandom_range(0, 99) < 70);
      end else if (k < 1000) begin
        vPct = 100; rel = 1'b1;
      end else if (k < 1100) begin
        vPct = 80; wPct = 15; rel = 1'b0;
      end else if (k < 1151) begin
        vPct = 80; wPct = 15; rel = 1'b1;
      end else if (k < 1231) begin
        vPct = 0; rel = 1'b1;
      end else begin
        vPct = ((k / 100) % 2 == 1) ? 25 : 70;
        rel  = ($urandom_range(0, 99) < 60);
      end
      reqValid[i] = ($urandom_range(0, 99) < vPct);
      if (k >= 800 && k < 1000) begin
        if ($urandom_range(0, 9) == 0) burstWe[i] = !burstWe[i];
        reqWe[i] = burstWe[i];
      end else begin
        reqWe[i] = ($urandom_range(0, 99) < wPct);
      end
      reqAddr[i]   = AB'($urandom);
      reqWdata[i]  = DB'($urandom);
      padRdata[i]  = DB'($urandom);
      padRvalid[i] = 1'b0;
      if (rel && padHead[i] != padTail[i] && padT[i][padHead[i] % 256] <= k) begin
        padRvalid[i] = 1'b1;
        padHead[i]++;
      end
    end
  endtask

  task automatic verifyCycle(input int k);
    int s;
    bit rdyExp;
    int idle;
    int turn;
    int start;
    bit dec;
    s = k % 64;
    for (int i = 0; i < 2; i++) begin
      if (expAcc[i][s]) begin
        holdAddr[i] = expAddrS[i][s];
        checkOutput($sformatf("u%0d.ce_n@%0d", i, k), 32'(ceN[i]), 32'd0);
        checkOutput($sformatf("u%0d.we_n@%0d", i, k), 32'(weN[i]), 32'(!expWe[i][s]));
        checkOutput($sformatf("u%0d.oe_n@%0d", i, k), 32'(oeN[i]), 32'(expWe[i][s]));
        checkOutput($sformatf("u%0d.wde@%0d", i, k), 32'(padWde[i]), 32'(expWe[i][s]));
        if (expWe[i][s])
          checkOutput($sformatf("u%0d.wdata@%0d", i, k), 32'(padWdata[i]), 32'(expWdS[i][s]));
      end else begin
        checkOutput($sformatf("u%0d.ce_n@%0d", i, k), 32'(ceN[i]), 32'd1);
        checkOutput($sformatf("u%0d.we_n@%0d", i, k), 32'(weN[i]), 32'd1);
        checkOutput($sformatf("u%0d.oe_n@%0d", i, k), 32'(oeN[i]), 32'd1);
        checkOutput($sformatf("u%0d.wde@%0d", i, k), 32'(padWde[i]), 32'd0);
      end
      expAcc[i][s] = 1'b0;
      checkOutput($sformatf("u%0d.addr@%0d", i, k), 32'(padAddr[i]), 32'(holdAddr[i]));
      checkOutput($sformatf("u%0d.rd_valid@%0d", i, k), 32'(rdValid[i]), 32'(expRdValid[i]));
      checkOutput($sformatf("u%0d.rd_data@%0d", i, k), 32'(rdData[i]), 32'(expRdData[i]));
      rdyExp = !reset && (k >= accessEnd[i]) && (outCount[i] < MXP[i]);
      checkOutput($sformatf("u%0d.req_ready@%0d", i, k), 32'(reqReady[i]), 32'(rdyExp));

      if (ceN[i] === 1'b0 && oeN[i] === 1'b0) begin
        padT[i][padTail[i] % 256] = k + LAT;
        padTail[i]++;
      end

      if (reset) begin
        for (int j = 0; j < 64; j++) expAcc[i][j] = 1'b0;
        accessEnd[i]  = k;
        lastValid[i]  = 1'b0;
        outCount[i]   = 0;
        groupCnt[i]   = 0;
        expRdValid[i] = 1'b0;
        expRdData[i]  = '0;
        holdAddr[i]   = '0;
      end else begin
        dec = 1'b0;
        expRdValid[i] = 1'b0;
        if (padRvalid[i] && outCount[i] > 0) begin
          groupCnt[i]++;
          if (groupCnt[i] == WSP[i] + 1) begin
            groupCnt[i]   = 0;
            expRdValid[i] = 1'b1;
            expRdData[i]  = padRdata[i];
            dec = 1'b1;
          end
        end
        if (rdyExp && reqValid[i]) begin
          idle = k - accessEnd[i];
          if (idle > 3) idle = 3;
          turn = 0;
          if (lastValid[i] && reqWe[i] != lastWe[i] && TAP[i] > idle) turn = TAP[i] - idle;
          start = k + 1 + turn;
          for (int c = start; c <= start + WSP[i]; c++) begin
            expAcc[i][c % 64]   = 1'b1;
            expWe[i][c % 64]    = reqWe[i];
            expAddrS[i][c % 64] = reqAddr[i];
            expWdS[i][c % 64]   = reqWdata[i];
          end
          accessEnd[i] = start + WSP[i];
          lastValid[i] = 1'b1;
          lastWe[i]    = reqWe[i];
          if (!reqWe[i]) outCount[i]++;
        end
        if (dec) outCount[i]--;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      reqValid[i] = 1'b0; reqWe[i] = 1'b0; reqAddr[i] = '0; reqWdata[i] = '0;
      padRdata[i] = '0; padRvalid[i] = 1'b0;
      for (int j = 0; j < 64; j++) expAcc[i][j] = 1'b0;
      holdAddr[i] = '0; accessEnd[i] = -1; lastValid[i] = 1'b0; lastWe[i] = 1'b0;
      outCount[i] = 0; groupCnt[i] = 0; expRdValid[i] = 1'b0; expRdData[i] = '0;
      burstWe[i] = 1'b0; padHead[i] = 0; padTail[i] = 0;
    end
    repeat (3) @(posedge clk);
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      applyStimulus(k);
      #1;
      verifyCycle(k);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sram_pad_ctrl.md
# sram_pad_ctrl

Request-level SRAM controller placed directly above the ice40 SRAM pad I/O block. It converts a valid/ready read/write request stream into the pad-side `pad_*` control, address and data signals, with configurable wait states and bus-turnaround cycles. It matches in-order read returns from the pad block to their requests and delivers one read response per read request. Unlike the bare pad block, it enforces a cap on outstanding reads and discards stale returns after reset.

## Interface
Parameters:
- `ADDR_BITS`, 20: address width.
- `DATA_BITS`, 16: data width.
- `WAIT_STATES`, 0: extra cycles each access is held on the pads. Range 0–7.
- `TURNAROUND`, 1: dead cycles required between accesses of opposite direction. Range 0–3.
- `MAX_OUTSTANDING`, 4: maximum reads issued but not yet answered. Range 1–15.

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller accepts the request this cycle.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_BITS: request address.
- `req_wdata` in DATA_BITS: write data.
- `rd_valid` out 1: read response strobe. This is a single-cycle pulse with no backpressure.
- `rd_data` out DATA_BITS: read response data.
- `pad_addr` out ADDR_BITS: address to the pad block.
- `pad_write_data` out DATA_BITS: write data to the pad block.
- `pad_write_data_enable` out 1: data bus drive enable.
- `pad_ce_n`, `pad_we_n`, `pad_oe_n` out 1 each: active-low SRAM strobes.
- `pad_read_data` in DATA_BITS: read data from the pad block.
- `pad_read_data_valid` in 1: read return strobe from the pad block.

## Operation
- States:
  - IDLE: no access on the pads.
  - TURN: bus turnaround.
  - ACCESS: a request is on the pads.
- All `pad_*` outputs and `rd_*` outputs are registered.
- Reset values:
  - `pad_ce_n`, `pad_we_n`, `pad_oe_n` = 1.
  - `pad_write_data_enable` = 0.
  - `pad_addr`, `pad_write_data`, `rd_data` = 0.
  - `rd_valid` = 0.
  - `req_ready` = 0 during reset.
  - State = IDLE; all counters = 0; the last-direction record is invalid.
- Idle pad values (IDLE and TURN):
  - `ce_n` = `we_n` = `oe_n` = 1 and `write_data_enable` = 0.
  - `addr` and `wdata` hold their last values.
- `req_ready` is 1 when both hold:
  - the state is IDLE or the final cycle of ACCESS;
  - the outstanding count is below `MAX_OUTSTANDING`.
  - `req_ready` never depends on `req_we`, `req_addr` or `req_wdata`.
- Accept: `req_valid` and `req_ready` high at the same edge.
  - Addr and data are latched.
  - The next state is ACCESS, or TURN if turnaround is owed.
- Turnaround is owed when the accepted direction differs from the last access direction and that record is valid.
  - Cycles inserted = max(0, `TURNAROUND` − idle cycles since the last ACCESS ended).
  - The idle counter saturates at 3.
- ACCESS lasts 1+`WAIT_STATES` cycles.
  - Write: `ce_n` = 0, `we_n` = 0, `oe_n` = 1, `write_data_enable` = 1.
  - Read: `ce_n` = 0, `we_n` = 1, `oe_n` = 0, `write_data_enable` = 0.
  - Addr and wdata are stable for the whole access.
- Outstanding counter:
  - +1 on read accept.
  - −1 on each forwarded return.
  - Accept and forward in the same cycle leaves it unchanged.
- Return matching:
  - Each read produces 1+`WAIT_STATES` `pad_read_data_valid` pulses.
  - A pulse counter modulo 1+`WAIT_STATES` forwards only the last pulse of each group.
  - Pulses are dropped when the outstanding count is 0 (stale returns after reset).
- Reset in mid-access:
  - The next cycle shows idle pad values.
  - The outstanding count and pulse counter clear.
  - No `rd_valid` is produced for reads issued before reset.

## Timing
- Request accepted at edge N: the pads show the access in cycles N+1 through N+1+`WAIT_STATES`.
- Same-direction back-to-back requests with `WAIT_STATES`=0 run one access per cycle, with `ce_n` held low continuously.
- Direction change with zero idle cycles: `ce_n` high for `TURNAROUND` cycles between the two accesses.
- `rd_valid` pulses one cycle after the forwarded `pad_read_data_valid`, with `rd_data` = the `pad_read_data` from that cycle.
- With `MAX_OUTSTANDING` reads in flight, `req_ready` = 0 until a return is forwarded.
  - `req_ready` rises in the same cycle the counter decrements.

## Test plan
- Reset check: after reset, all pad strobes = 1, `write_data_enable` = 0, and `req_ready` = 1 one cycle after reset deasserts.
- Write 0x1234 to 0x00010 with `WAIT_STATES`=0: one cycle of `ce_n`/`we_n` = 0, addr = 0x00010, wdata = 0x1234, `write_data_enable` = 1.
- Four back-to-back reads to 0–3, pad model echoing data = addr+0x100 at latency 3:
  - `ce_n` stays low for 4 cycles;
  - `rd_valid` pulses 4 times with data 0x100–0x103 in order.
- Write → read → write with `TURNAROUND`=2:
  - `ce_n` high for exactly 2 cycles at each direction change;
  - the same sequence with 2 idle cycles between requests inserts 0 extra cycles.
- `WAIT_STATES`=2 read of 0x5 with `pad_read_data_valid` for 3 consecutive cycles: `oe_n` low for 3 cycles and exactly one `rd_valid`.
- Outstanding limit and reset:
  - With `MAX_OUTSTANDING`=2 and returns withheld: `req_ready` drops after the 2nd read and returns after the first return.
  - Reset asserted with 2 reads in flight, then 2 late pad returns: zero `rd_valid` pulses.
